// File: rtl/rob_alloc.sv
// Reorder-buffer slot allocator: hands out ROB tags in program order,
// tracks occupancy against in-order commits, and holds off issue after a flush.
module rob_alloc #(
  parameter int ROB_SLOTS    = 16,
  parameter int ROB_IDX_BITS = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    allocReq,
  output logic                    allocGnt,
  output logic [ROB_IDX_BITS-1:0] allocIdx,
  input  logic                    commitValid,
  input  logic [ROB_IDX_BITS-1:0] commitIdx,
  output logic                    full,
  output logic                    empty,
  output logic [ROB_IDX_BITS:0]   count,
  output logic                    orderErr
);

  localparam int CW   = ROB_IDX_BITS + 1;
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FC_INIT = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

  localparam logic [CW-1:0]           SLOTS = CW'(ROB_SLOTS);
  localparam logic [ROB_IDX_BITS-1:0] LAST  = ROB_IDX_BITS'(ROB_SLOTS - 1);
  localparam logic [FC_W-1:0]         FC_LD = FC_W'(FC_INIT);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                  state, state_n;
  logic [ROB_IDX_BITS-1:0] tail, tail_n;
  logic [ROB_IDX_BITS-1:0] head, head_n;
  logic [CW-1:0]           count_n;
  logic [FC_W-1:0]         fcnt, fcnt_n;
  logic                    err_n;
  logic                    run;
  logic                    grant;
  logic                    accept;
  logic                    pop;

  assign full     = (count == SLOTS);
  assign empty    = (count == '0);
  assign run      = (state == RUN);
  assign grant    = allocReq && !full && !clear && run;
  assign accept   = commitValid && !clear && run;
  assign pop      = accept && !empty;
  assign allocGnt = grant;
  assign allocIdx = tail;

  always_comb begin
    state_n = state;
    tail_n  = tail;
    head_n  = head;
    count_n = count;
    fcnt_n  = fcnt;
    err_n   = orderErr;
    if (clear) begin
      tail_n  = '0;
      head_n  = '0;
      count_n = '0;
      if (FLUSH_CYCLES == 0) begin
        state_n = RUN;
      end else begin
        state_n = FLUSH;
        fcnt_n  = FC_LD;
      end
    end else if (!run) begin
      if (fcnt == '0) state_n = RUN;
      else            fcnt_n  = fcnt - 1'b1;
    end else begin
      if (grant)
        tail_n = (tail == LAST) ? '0 : tail + 1'b1;
      // an out-of-order commit still retires the head slot
      if (accept && empty)
        err_n = 1'b1;
      if (pop) begin
        if (commitIdx != head) err_n = 1'b1;
        head_n = (head == LAST) ? '0 : head + 1'b1;
      end
      count_n = count + CW'(grant) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      tail     <= '0;
      head     <= '0;
      count    <= '0;
      fcnt     <= '0;
      orderErr <= 1'b0;
    end else begin
      state    <= state_n;
      tail     <= tail_n;
      head     <= head_n;
      count    <= count_n;
      fcnt     <= fcnt_n;
      orderErr <= err_n;
    end
  end

endmodule

// File: tb/tb_rob_alloc.sv
// Bench for rob_alloc: directed scenarios plus random traffic
// compared against a queue-based model of ROB occupancy.
module tb_rob_alloc;

  localparam int FC = 2;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        allocReq;
  logic        allocGnt;
  logic [3:0]  allocIdx;
  logic        commitValid;
  logic [3:0]  commitIdx;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        orderErr;
  logic [12:0] act;

  int tests = 0;
  int fails = 0;

  logic [3:0] q[$];
  int         m_tail;
  int         m_blk;
  bit         m_err;

  rob_alloc #(
    .ROB_SLOTS(16),
    .ROB_IDX_BITS(4),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .allocReq(allocReq),
    .allocGnt(allocGnt),
    .allocIdx(allocIdx),
    .commitValid(commitValid),
    .commitIdx(commitIdx),
    .full(full),
    .empty(empty),
    .count(count),
    .orderErr(orderErr)
  );

  assign act = {allocGnt, allocIdx, count, full, empty, orderErr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] exp_vec();
    logic       g;
    logic [4:0] n;
    n = 5'(q.size());
    g = allocReq && q.size() < 16 && !clear && m_blk == 0;
    return {g, 4'(m_tail), n, n == 5'd16, n == 5'd0, m_err};
  endfunction

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    m_blk  = 0;
    m_err  = 0;
  endtask

  task automatic idle();
    clear       = 0;
    allocReq    = 0;
    commitValid = 0;
    commitIdx   = 0;
  endtask

  // advance the model with the inputs currently applied, then clock
  task automatic tick();
    bit g, a;
    g = allocReq && q.size() < 16 && !clear && m_blk == 0;
    a = commitValid && !clear && m_blk == 0;
    if (clear) begin
      q.delete();
      m_tail = 0;
      m_blk  = FC;
    end else begin
      if (m_blk > 0) m_blk--;
      if (a) begin
        if (q.size() == 0) m_err = 1;
        else begin
          if (commitIdx != q[0]) m_err = 1;
          void'(q.pop_front());
        end
      end
      if (g) begin
        q.push_back(4'(m_tail));
        m_tail = (m_tail + 1) % 16;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    idle();
    rst = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic grant_n(input int n);
    allocReq = 1;
    repeat (n) tick();
    allocReq = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    model_reset();
    #1;
    tests++;
    if (act !== 13'b0_0000_00000_0_1_0) begin
      fails++;
      $display("FAIL reset_outputs act=%b exp=%b", act, 13'b0_0000_00000_0_1_0);
    end
    @(negedge clk);
    rst = 1;
    #1;
    tests++;
    if (act !== exp_vec()) begin
      fails++;
      $display("FAIL reset_release act=%b exp=%b", act, exp_vec());
    end
  endtask

  task automatic test_fill();
    allocReq = 1;
    for (int i = 0; i < 18; i++) begin
      #1;
      tests++;
      if (act !== exp_vec()) begin
        fails++;
        $display("FAIL fill_c%0d act=%b exp=%b", i, act, exp_vec());
      end
      tests++;
      if (i < 16 && (allocGnt !== 1'b1 || allocIdx !== 4'(i))) begin
        fails++;
        $display("FAIL fill_idx_c%0d gnt=%b idx=%0d exp idx=%0d", i, allocGnt, allocIdx, i);
      end else if (i >= 16 && (allocGnt !== 1'b0 || full !== 1'b1 || count !== 5'd16)) begin
        fails++;
        $display("FAIL fill_full_c%0d gnt=%b full=%b count=%0d exp 0/1/16", i, allocGnt, full, count);
      end
      tick();
    end
  endtask

  task automatic test_wrap_full();
    allocReq    = 1;
    commitValid = 1;
    commitIdx   = 0;
    #1;
    tests++;
    if (allocGnt !== 1'b0 || act !== exp_vec()) begin
      fails++;
      $display("FAIL nobypass gnt=%b act=%b exp=%b", allocGnt, act, exp_vec());
    end
    tick();
    commitValid = 0;
    #1;
    tests++;
    if (allocGnt !== 1'b1 || allocIdx !== 4'd0 || act !== exp_vec()) begin
      fails++;
      $display("FAIL wrap_grant gnt=%b idx=%0d exp 1/0", allocGnt, allocIdx);
    end
    tick();
    tests++;
    if (count !== 5'd16 || full !== 1'b1) begin
      fails++;
      $display("FAIL wrap_count count=%0d exp 16", count);
    end
    allocReq = 0;
  endtask

  task automatic test_steady();
    pulse_reset();
    grant_n(5);
    for (int i = 0; i < 20; i++) begin
      allocReq    = 1;
      commitValid = 1;
      commitIdx   = q[0];
      #1;
      tests++;
      if (act !== exp_vec() || count !== 5'd5) begin
        fails++;
        $display("FAIL steady_c%0d act=%b exp=%b", i, act, exp_vec());
      end
      tick();
    end
    idle();
    #1;
    tests++;
    if (count !== 5'd5 || orderErr !== 1'b0 || allocIdx !== 4'd9) begin
      fails++;
      $display("FAIL steady_end count=%0d err=%b idx=%0d exp 5/0/9", count, orderErr, allocIdx);
    end
  endtask

  task automatic test_clear();
    pulse_reset();
    grant_n(7);
    allocReq = 1;
    clear    = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (act !== exp_vec()) begin
        fails++;
        $display("FAIL clear_c%0d act=%b exp=%b", i, act, exp_vec());
      end
      tests++;
      if (i < 3 && allocGnt !== 1'b0) begin
        fails++;
        $display("FAIL clear_block_c%0d gnt=%b exp 0", i, allocGnt);
      end else if (i == 3 && (allocGnt !== 1'b1 || allocIdx !== 4'd0 || empty !== 1'b1)) begin
        fails++;
        $display("FAIL clear_resume gnt=%b idx=%0d empty=%b exp 1/0/1", allocGnt, allocIdx, empty);
      end
      tick();
      clear = 0;
    end
    allocReq = 0;
  endtask

  task automatic test_order_err();
    pulse_reset();
    grant_n(3);
    commitValid = 1;
    commitIdx   = 0;
    tick();
    commitIdx = 1;
    tick();
    commitIdx = 3;
    #1;
    tests++;
    if (orderErr !== 1'b0) begin
      fails++;
      $display("FAIL err_early err=%b exp 0", orderErr);
    end
    tick();
    commitValid = 0;
    #1;
    tests++;
    if (orderErr !== 1'b1 || count !== 5'd0 || act !== exp_vec()) begin
      fails++;
      $display("FAIL err_set err=%b count=%0d exp 1/0", orderErr, count);
    end
    clear = 1;
    tick();
    clear = 0;
    repeat (3) tick();
    tests++;
    if (orderErr !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky err=%b exp 1", orderErr);
    end
    pulse_reset();
    #1;
    tests++;
    if (orderErr !== 1'b0) begin
      fails++;
      $display("FAIL err_rst err=%b exp 0", orderErr);
    end
  endtask

  task automatic test_empty_commit();
    pulse_reset();
    commitValid = 1;
    commitIdx   = 0;
    tick();
    commitValid = 0;
    #1;
    tests++;
    if (orderErr !== 1'b1 || count !== 5'd0 || act !== exp_vec()) begin
      fails++;
      $display("FAIL empty_commit err=%b count=%0d exp 1/0", orderErr, count);
    end
    grant_n(4);
    clear = 1;
    tick();
    clear = 0;
    #2;
    rst = 0;
    model_reset();
    #1;
    tests++;
    if (act !== 13'b0_0000_00000_0_1_0) begin
      fails++;
      $display("FAIL flush_rst act=%b exp=%b", act, 13'b0_0000_00000_0_1_0);
    end
    @(negedge clk);
    rst      = 1;
    allocReq = 1;
    #1;
    tests++;
    if (allocGnt !== 1'b1 || allocIdx !== 4'd0) begin
      fails++;
      $display("FAIL first_gnt gnt=%b idx=%0d exp 1/0", allocGnt, allocIdx);
    end
    tick();
    allocReq = 0;
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      allocReq    = ($urandom_range(0, 3) != 0);
      commitValid = ($urandom_range(0, 2) == 0) || (q.size() == 16);
      if (q.size() > 0 && $urandom_range(0, 19) != 0) commitIdx = q[0];
      else commitIdx = 4'($urandom);
      clear = ($urandom_range(0, 40) == 0);
      #1;
      tests++;
      if (act !== exp_vec()) begin
        fails++;
        $display("FAIL random_c%0d act=%b exp=%b", i, act, exp_vec());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_fill();
    test_wrap_full();
    test_steady();
    test_clear();
    test_order_err();
    test_empty_commit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
